// File: rtl/display_pkg.sv
// Shared constants, scan state type and small helpers for the 8-digit
// multiplexed 7-segment display path.
package display_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int SEG_W      = 7;
  localparam int FRAME_W    = NUM_DIGITS * SEG_W;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  // Per-pin polarity: a logical 1 (lit/selected) becomes 0 on an active-low pin.
  function automatic logic apply_pol(input logic value, input logic active_low);
    return value ^ active_low;
  endfunction

  function automatic logic [SEG_W-1:0] get_digit(input logic [FRAME_W-1:0] frame,
                                                 input logic [IDX_W-1:0]   idx);
    return frame[idx*SEG_W +: SEG_W];
  endfunction

endpackage

// File: rtl/display_scanner_scan_timer.sv
// Phase timer: counts cycles from 0 and flags the last cycle of a phase of
// i_limit cycles; it wraps to 0 on its own so it never runs past the limit.
module scan_timer #(
  parameter int W = 16
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_clear,
  input  logic [W-1:0] i_limit,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  assign o_tc = (r_count == (i_limit - W'(1)));

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear || o_tc) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + W'(1);
    end
  end

endmodule

// File: rtl/display_scanner.sv
// Double-buffered frame sink that time-multiplexes 8 digits onto a shared
// segment bus; new frames take effect only at frame boundaries.
module display_scanner
  import display_pkg::*;
#(
  parameter int DWELL_CYCLES   = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic [FRAME_W-1:0]    i_frame_in,
  input  logic                  i_frame_valid,
  output logic                  o_frame_ready,
  input  logic [NUM_DIGITS-1:0] i_blank_mask,
  output logic [SEG_W-1:0]      o_seg_out,
  output logic [NUM_DIGITS-1:0] o_dig_out,
  output logic                  o_frame_done
);

  localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [SEG_W-1:0]      SEG_OFF = {SEG_W{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_ACTIVE_LOW}};

  scan_state_t           r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [FRAME_W-1:0]    r_active;
  logic [FRAME_W-1:0]    r_pending;
  logic                  r_ready;
  logic [SEG_W-1:0]      r_seg;
  logic [NUM_DIGITS-1:0] r_dig;
  logic                  r_done;

  scan_state_t           w_state_nx;
  logic [CW-1:0]         w_limit;
  logic                  w_tc;
  logic                  w_blank_end;
  logic                  w_show_end;
  logic                  w_last;
  logic                  w_done_nx;
  logic                  w_promote;
  logic                  w_lit;
  logic [IDX_W-1:0]      w_idx_nx;
  logic [FRAME_W-1:0]    w_active_nx;
  logic [SEG_W-1:0]      w_seg_sel;
  logic [NUM_DIGITS-1:0] w_dig_sel;
  logic [SEG_W-1:0]      w_seg_nx;
  logic [NUM_DIGITS-1:0] w_dig_nx;

  assign w_limit     = (r_state == SHOW) ? CW'(DWELL_CYCLES) : CW'(BLANK_CYCLES);
  assign w_blank_end = (r_state == BLANK) && ((BLANK_CYCLES == 0) || w_tc);
  assign w_show_end  = (r_state == SHOW) && w_tc;
  assign w_last      = (r_idx == IDX_W'(NUM_DIGITS - 1));
  assign w_done_nx   = i_enable && w_show_end && w_last;
  // Pending only moves to active at a frame boundary or while the display is dark.
  assign w_promote   = !r_ready && (!i_enable || w_done_nx);
  assign w_active_nx = w_promote ? r_pending : r_active;
  assign w_idx_nx    = !i_enable ? '0 :
                       w_show_end ? (w_last ? '0 : r_idx + IDX_W'(1)) : r_idx;

  scan_timer #(.W(CW)) u_timer (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (!i_enable || w_blank_end || w_show_end),
    .i_limit (w_limit),
    .o_tc    (w_tc)
  );

  always_comb begin
    w_state_nx = r_state;
    if (!i_enable) begin
      w_state_nx = BLANK;
    end else if (w_blank_end) begin
      w_state_nx = SHOW;
    end else if (w_show_end) begin
      w_state_nx = (BLANK_CYCLES == 0) ? SHOW : BLANK;
    end
  end

  // Pin values are computed for the state being entered so they change with it.
  assign w_lit     = i_enable && (w_state_nx == SHOW);
  assign w_seg_sel = w_lit ? get_digit(w_active_nx, w_idx_nx) : '0;
  assign w_dig_sel = (w_lit && !i_blank_mask[w_idx_nx]) ? (NUM_DIGITS'(1) << w_idx_nx) : '0;

  always_comb begin
    w_seg_nx = '0;
    w_dig_nx = '0;
    for (int b = 0; b < SEG_W; b++) begin
      w_seg_nx[b] = apply_pol(w_seg_sel[b], SEG_ACTIVE_LOW);
    end
    for (int b = 0; b < NUM_DIGITS; b++) begin
      w_dig_nx[b] = apply_pol(w_dig_sel[b], DIG_ACTIVE_LOW);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= BLANK;
      r_idx     <= '0;
      r_active  <= '0;
      r_pending <= '0;
      r_ready   <= 1'b1;
      r_seg     <= SEG_OFF;
      r_dig     <= DIG_OFF;
      r_done    <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_idx    <= w_idx_nx;
      r_active <= w_active_nx;
      r_seg    <= w_seg_nx;
      r_dig    <= w_dig_nx;
      r_done   <= w_done_nx;
      // Ready is low whenever pending is full, so capture and promotion are exclusive.
      if (w_promote) begin
        r_ready <= 1'b1;
      end else if (i_frame_valid && r_ready) begin
        r_pending <= i_frame_in;
        r_ready   <= 1'b0;
      end
    end
  end

  assign o_frame_ready = r_ready;
  assign o_seg_out     = r_seg;
  assign o_dig_out     = r_dig;
  assign o_frame_done  = r_done;

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner with DWELL=4, BLANK=1 (digit period 5, frame period 40).
module tb_display_scanner;

  logic        clk;
  logic        rst;
  logic        en;
  logic [55:0] frame_in;
  logic        frame_vld;
  logic        frame_rdy;
  logic [7:0]  mask;
  logic [6:0]  seg;
  logic [7:0]  dig;
  logic        done;

  int total;
  int bad;

  // Reference model: position since the last restart, plus buffer contents.
  int          pos;
  logic [55:0] m_act;
  logic [55:0] m_pend;
  logic        m_full;
  logic [6:0]  exp_seg;
  logic [7:0]  exp_dig;
  logic        exp_rdy;
  logic        exp_done;

  localparam logic [55:0] F1 = 56'h0000_0000_0000_033F;
  localparam logic [55:0] F2 = 56'h12_3456_789A_BCDE;
  localparam logic [55:0] F3 = 56'hAB_CDEF_0123_45DB;
  localparam logic [55:0] F4 = 56'hFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic        rst;
    logic        en;
    logic        vld;
    logic [55:0] frame;
    logic [7:0]  mask;
    logic [6:0]  seg;
    logic [7:0]  dig;
    logic        rdy;
    logic        done;
  } vec_t;

  vec_t tbl[7];

  display_scanner #(
    .DWELL_CYCLES  (4),
    .BLANK_CYCLES  (1),
    .SEG_ACTIVE_LOW(1'b1),
    .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_enable     (en),
    .i_frame_in   (frame_in),
    .i_frame_valid(frame_vld),
    .o_frame_ready(frame_rdy),
    .i_blank_mask (mask),
    .o_seg_out    (seg),
    .o_dig_out    (dig),
    .o_frame_done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one edge's inputs, step the clock, sample #1 later and advance the model.
  task automatic apply(input logic r, input logic e, input logic v,
                       input logic [55:0] fr, input logic [7:0] mk);
    logic       full_prev;
    int         m;
    int         d;
    logic [7:0] onehot;
    rst       = r;
    en        = e;
    frame_vld = v;
    frame_in  = fr;
    mask      = mk;
    @(posedge clk);
    #1;
    full_prev = m_full;
    if (r) begin
      pos = 0; m_act = '0; m_pend = '0; m_full = 1'b0;
      exp_seg = 7'h7F; exp_dig = 8'hFF; exp_done = 1'b0;
    end else begin
      if (v && !full_prev) begin
        m_pend = fr;
        m_full = 1'b1;
      end
      if (!e) begin
        pos = 0;
        exp_done = 1'b0;
        if (full_prev) begin
          m_act = m_pend;
          m_full = 1'b0;
        end
        exp_seg = 7'h7F;
        exp_dig = 8'hFF;
      end else begin
        pos++;
        m = pos % 40;
        exp_done = (m == 0);
        if (exp_done && full_prev) begin
          m_act = m_pend;
          m_full = 1'b0;
        end
        if (m % 5 == 0) begin
          exp_seg = 7'h7F;
          exp_dig = 8'hFF;
        end else begin
          d = m / 5;
          exp_seg = ~m_act[d*7 +: 7];
          onehot = 8'b1 << d;
          exp_dig = mk[d] ? 8'hFF : ~onehot;
        end
      end
    end
    exp_rdy = !m_full;
  endtask

  task automatic check_model(input string nm);
    check({nm, "_seg"},  seg,       exp_seg);
    check({nm, "_dig"},  dig,       exp_dig);
    check({nm, "_rdy"},  frame_rdy, exp_rdy);
    check({nm, "_done"}, done,      exp_done);
  endtask

  initial begin
    total = 0; bad = 0;
    pos = 0; m_act = '0; m_pend = '0; m_full = 1'b0;
    rst = 1'b1; en = 1'b0; frame_vld = 1'b0; frame_in = '0; mask = '0;

    //        rst   en    vld   frame mask   seg    dig    rdy   done
    tbl[0] = '{1'b1, 1'b1, 1'b0, '0,   8'h00, 7'h7F, 8'hFF, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, F1,   8'h00, 7'h7F, 8'hFE, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, '0,   8'h00, 7'h7F, 8'hFE, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, '0,   8'h00, 7'h7F, 8'hFE, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, '0,   8'h00, 7'h7F, 8'hFE, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, '0,   8'h00, 7'h7F, 8'hFF, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, '0,   8'h00, 7'h7F, 8'hFD, 1'b0, 1'b0};

    for (int i = 0; i < 7; i++) begin
      apply(tbl[i].rst, tbl[i].en, tbl[i].vld, tbl[i].frame, tbl[i].mask);
      check($sformatf("tbl%0d_seg", i),  seg,       tbl[i].seg);
      check($sformatf("tbl%0d_dig", i),  dig,       tbl[i].dig);
      check($sformatf("tbl%0d_rdy", i),  frame_rdy, tbl[i].rdy);
      check($sformatf("tbl%0d_done", i), done,      tbl[i].done);
    end

    // Dark frame, then F1; F2 is offered while pending is full and held until taken.
    for (int k = 7; k <= 80; k++) begin
      apply(1'b0, 1'b1, (k >= 10 && k <= 41), F2, 8'h00);
      check_model("scan");
      if (k == 20) check("held_rdy", frame_rdy, 1'b0);
      if (k == 40) check("boundary_done", done, 1'b1);
      if (k == 41) check("f1_d0_seg", seg, 7'h40);
      if (k == 41) check("f1_d0_dig", dig, 8'hFE);
      if (k == 46) check("f1_d1_seg", seg, 7'h79);
      if (k == 45) check("f2_taken_rdy", frame_rdy, 1'b0);
    end

    // Leading-digit suppression on digit 7 only.
    for (int k = 81; k <= 120; k++) begin
      apply(1'b0, 1'b1, 1'b0, '0, 8'h80);
      check_model("mask");
      if (k == 117) check("mask_d7_dig", dig, 8'hFF);
      if (k == 112) check("mask_d6_dig", dig, 8'hBF);
    end

    // Capture F3, then drop enable in digit 3's dwell.
    for (int k = 121; k <= 137; k++) begin
      apply(1'b0, 1'b1, (k == 121), F3, 8'h00);
      check_model("pre_dis");
    end
    apply(1'b0, 1'b0, 1'b0, '0, 8'h00);
    check_model("dis");
    check("dis_seg", seg, 7'h7F);
    check("dis_dig", dig, 8'hFF);
    check("dis_rdy", frame_rdy, 1'b1);
    apply(1'b0, 1'b0, 1'b0, '0, 8'h00);
    check_model("dis2");
    apply(1'b0, 1'b1, 1'b0, '0, 8'h00);
    check_model("reen");
    check("reen_dig", dig, 8'hFE);
    check("reen_seg", seg, 7'h24);
    for (int k = 2; k <= 41; k++) begin
      apply(1'b0, 1'b1, 1'b0, '0, 8'h00);
      check_model("post_en");
    end

    // Reset with a pending frame discards it.
    apply(1'b0, 1'b1, 1'b1, F4, 8'h00);
    check("f4_taken_rdy", frame_rdy, 1'b0);
    apply(1'b1, 1'b1, 1'b0, '0, 8'h00);
    check_model("rst2");
    check("rst2_rdy", frame_rdy, 1'b1);
    for (int k = 1; k <= 45; k++) begin
      apply(1'b0, 1'b1, 1'b0, '0, 8'h00);
      check_model("post_rst");
      if (k == 2) check("post_rst_seg", seg, 7'h7F);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
